// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round count, FSM states,
// round-constant table and word rotation.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_EMIT
  } ks_state_e;

  // Round constant for round idx (1..10) in the top byte; 0 for any other index.
  function automatic logic [31:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 32'h0100_0000;
      4'd2:    rcon = 32'h0200_0000;
      4'd3:    rcon = 32'h0400_0000;
      4'd4:    rcon = 32'h0800_0000;
      4'd5:    rcon = 32'h1000_0000;
      4'd6:    rcon = 32'h2000_0000;
      4'd7:    rcon = 32'h4000_0000;
      4'd8:    rcon = 32'h8000_0000;
      4'd9:    rcon = 32'h1B00_0000;
      4'd10:   rcon = 32'h3600_0000;
      default: rcon = 32'h0000_0000;
    endcase
  endfunction

  // RotWord(a,b,c,d) = (b,c,d,a), a being the most significant byte.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/Sbox.sv
// AES forward S-box, one byte, purely combinational lookup.
module Sbox (
  input  logic [7:0] Inbyte,
  output logic [7:0] Sbyte
);

  // Entry 0x00 sits in the most significant byte of the table.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte k lives at bit offset 8*(255-k); ~Inbyte == 255-Inbyte.
  assign Sbyte = SBOX_TABLE[{~Inbyte, 3'b000} +: 8];

endmodule

// File: rtl/inv_key_schedule.sv
// Iterative AES-128 decryption key scheduler: expands forward to the
// round-10 key, then walks the schedule backwards one key per handshake.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  ST_IDLE   | ready=1, waiting for start; rk_out holds the last key
//  ST_EXPAND | one forward round per cycle, cnt 1..10
//  ST_EMIT   | rk_valid=1, present round cnt; step back on handshake
module inv_key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         done
);

  ks_state_e    state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         done_q, done_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rc, sb_in, sb_rot, sb_out;
  logic [31:0] n0, n1, n2, n3;
  logic [31:0] p0, p1, p2, p3;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];
  assign rc = rcon(cnt_q);

  // The single S-box bank sees w3 going forward and the recovered w3 going back.
  assign sb_in  = (state_q == ST_EMIT) ? (w3 ^ w2) : w3;
  assign sb_rot = rot_word(sb_in);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    Sbox u_sbox (
      .Inbyte (sb_rot[8*i +: 8]),
      .Sbyte  (sb_out[8*i +: 8])
    );
  end

  assign n0 = w0 ^ sb_out ^ rc;
  assign n1 = n0 ^ w1;
  assign n2 = n1 ^ w2;
  assign n3 = n2 ^ w3;

  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign p0 = w0 ^ sb_out ^ rc;

  // Next-state, key and counter update.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = key_in;
          cnt_d   = 4'd1;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        key_d = {n0, n1, n2, n3};
        if (cnt_q == 4'(NR)) state_d = ST_EMIT;
        else                 cnt_d   = cnt_q + 4'd1;
      end
      ST_EMIT: begin
        if (rk_ready) begin
          if (cnt_q != 4'd0) begin
            key_d = {p0, p1, p2, p3};
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, key, counter and done-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign rk_valid = (state_q == ST_EMIT);
  assign rk_out   = key_q;
  assign rk_round = cnt_q;
  assign done     = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule with a scoreboard of expected round keys
// built from an independent forward key expansion.
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst, start, rk_ready;
  logic [127:0] key_in;
  logic         ready, rk_valid, done;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;

  always #5 clk = ~clk;

  inv_key_schedule dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .ready    (ready),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .done     (done)
  );

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ZERO = 128'h0;

  typedef struct packed {
    logic [3:0]   r;
    logic [127:0] k;
  } exp_t;

  exp_t         sb_q[$];
  logic [7:0]   sbox_t [256];
  logic [7:0]   rc_b [11];
  logic [127:0] got [11];
  int           checks = 0;
  int           errors = 0;
  int           done_cnt = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box derived from the GF(2^8) inverse plus affine map.
  task automatic build_tables();
    logic [7:0] inv, s, r;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_t[x] = s;
    end
    r = 8'h01;
    rc_b[0] = 8'h00;
    for (int j = 1; j <= 10; j++) begin
      rc_b[j] = r;
      r = gmul(r, 8'h02);
    end
  endtask

  function automatic logic [31:0] subrot(input logic [31:0] w);
    logic [31:0] t;
    t = {w[23:0], w[31:24]};
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  // Classic 44-word expansion; pushes round keys 10..0 to the scoreboard.
  task automatic push_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    exp_t e;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = subrot(t) ^ {rc_b[i/4], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 10; r >= 0; r--) begin
      e.r = 4'(r);
      e.k = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      sb_q.push_back(e);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge after the capture edge.
  task automatic do_start(input logic [127:0] key);
    chk("ready_idle", 128'(ready), 128'(1'b1));
    start  = 1'b1;
    key_in = key;
    push_key(key);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (rk_valid !== 1'b1 && n < 40) begin
      chk("ready_busy", 128'(ready), 128'(1'b0));
      @(negedge clk);
      n++;
    end
    chk("latency", 128'(n), 128'(10));
  endtask

  // mode 0: rk_ready always high; mode 1: random backpressure plus a 5-cycle stall at round 6.
  task automatic drain(input int mode, input bit hold, input bit restart, input logic [127:0] keyb);
    int         cyc = 0;
    int         stall = 0;
    int         dc0;
    bit         prev_stall = 1'b0;
    bit         rdy;
    logic [127:0] prev_out;
    logic [3:0] prev_round;
    exp_t       e;
    dc0 = done_cnt;
    while (sb_q.size() > 0 && cyc < 400) begin
      if (prev_stall) begin
        chk("stall_out", rk_out, prev_out);
        chk("stall_round", 128'(rk_round), 128'(prev_round));
      end
      if (mode == 0) chk("stream_valid", 128'(rk_valid), 128'(1'b1));
      if (hold) chk("ready_busy", 128'(ready), 128'(1'b0));
      if (mode == 0) rdy = 1'b1;
      else if (rk_valid === 1'b1 && rk_round == 4'd6 && stall < 5) begin
        rdy = 1'b0;
        stall++;
      end else rdy = ($urandom_range(0, 2) != 0);
      rk_ready = rdy;
      if (rk_valid === 1'b1 && rdy) begin
        e = sb_q.pop_front();
        chk("rk_round", 128'(rk_round), 128'(e.r));
        chk("rk_out", rk_out, e.k);
        if (rk_round <= 4'd10) got[rk_round] = rk_out;
        if (sb_q.size() == 0) begin
          start  = restart;
          key_in = restart ? keyb : key_in;
        end
      end
      prev_stall = (rk_valid === 1'b1) && !rdy;
      prev_out   = rk_out;
      prev_round = rk_round;
      @(negedge clk);
      cyc++;
    end
    chk("drain_timeout", 128'(cyc < 400), 128'(1'b1));
    chk("done_pulse", 128'(done), 128'(1'b1));
    chk("valid_after", 128'(rk_valid), 128'(1'b0));
    chk("ready_after", 128'(ready), 128'(1'b1));
    if (restart) push_key(keyb);
    @(negedge clk);
    start = 1'b0;
    chk("done_once", 128'(done_cnt - dc0), 128'(1));
    if (!restart) chk("done_low", 128'(done), 128'(1'b0));
  endtask

  initial begin
    int n;
    int dc0;
    rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
    build_tables();
    repeat (2) @(negedge clk);
    chk("rst_ready", 128'(ready), 128'(1'b1));
    chk("rst_valid", 128'(rk_valid), 128'(1'b0));
    chk("rst_out", rk_out, 128'h0);
    chk("rst_round", 128'(rk_round), 128'(0));
    chk("rst_done", 128'(done), 128'(1'b0));
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 key, full-rate streaming.
    do_start(KEY_FIPS);
    wait_valid();
    drain(0, 1'b0, 1'b0, '0);
    chk("fips_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips_r9", got[9], 128'hac7766f319fadc2128d12941575c006e);
    chk("fips_r1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_r0", got[0], KEY_FIPS);

    // All-zero key.
    do_start(KEY_ZERO);
    wait_valid();
    drain(0, 1'b0, 1'b0, '0);
    chk("zero_r10", got[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    chk("zero_r0", got[0], 128'h0);

    // Backpressure.
    do_start(KEY_FIPS);
    wait_valid();
    drain(1, 1'b0, 1'b0, '0);

    // start held high with another key while busy.
    do_start(KEY_FIPS);
    start  = 1'b1;
    key_in = KEY_ZERO;
    wait_valid();
    rk_ready = 1'b1;
    drain(0, 1'b1, 1'b0, '0);

    // Reset in the middle of EMIT.
    do_start(KEY_ZERO);
    wait_valid();
    rk_ready = 1'b1;
    n = 0;
    while (rk_round != 4'd4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_round4", 128'(rk_round), 128'(4));
    rst = 1'b1;
    dc0 = done_cnt;
    @(negedge clk);
    chk("mid_rst_valid", 128'(rk_valid), 128'(1'b0));
    chk("mid_rst_ready", 128'(ready), 128'(1'b1));
    chk("mid_rst_out", rk_out, 128'h0);
    chk("mid_rst_round", 128'(rk_round), 128'(0));
    chk("mid_rst_done", 128'(done), 128'(1'b0));
    rst = 1'b0;
    sb_q.delete();
    repeat (3) @(negedge clk);
    chk("mid_rst_no_done", 128'(done_cnt - dc0), 128'(0));
    do_start(KEY_FIPS);
    wait_valid();
    drain(1, 1'b0, 1'b0, '0);

    // Restart in the done cycle.
    do_start(KEY_FIPS);
    wait_valid();
    drain(0, 1'b0, 1'b1, KEY_ZERO);
    wait_valid();
    drain(0, 1'b0, 1'b0, '0);
    chk("restart_r10", got[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
